line_window: RTL and testbench
==============================

# line_window

Vertical window generator for the separable convolution datapath. It accepts a raster pixel stream one pixel per cycle and buffers the previous TAPS-1 lines in rotating row_bank instances. For every accepted pixel it emits a TAPS-tall column made of that pixel and the pixels directly above it. The vertical 1-D filter stage consumes this output.

## Interface
- WIDTH, 8, pixel width in bits
- DEPTH, 640, pixels per line (row_bank depth)
- TAPS, 3, window height in lines, ≥2; block instantiates TAPS-1 row_bank instances
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous reset, active-low (one clock; reset is synchronous and active-low)
- i_valid  in  1  input pixel valid
- i_sof  in  1  start of frame, qualified by i_valid; marks pixel (row 0, col 0)
- i_data  in  WIDTH  input pixel
- o_ready  out  1  block can accept a pixel
- o_valid  out  1  o_column holds a full valid window column
- o_column  out  TAPS*WIDTH  tap k at bits [k*WIDTH +: WIDTH]; tap 0 is oldest line, tap TAPS-1 is current pixel
- o_last  out  1  column belongs to line position DEPTH-1, qualified by o_valid
- i_ready  in  1  downstream accepts o_column

## Operation
- accept = i_valid & o_ready; o_ready = !o_valid | i_ready (single output stage; throughput 1 pixel/cycle).
- State: col (0..DEPTH-1), wr_bank (0..TAPS-2), lines (saturating 0..TAPS-1), FSM {FILL, RUN}.
- On accept, drive all banks with i_re=1 and i_addr=col. Drive bank wr_bank with i_we=1 and i_data. Other banks have i_we=0. With no accept, all i_re=0 and i_we=0, so bank outputs hold.
- row_bank read-before-write: bank wr_bank returns the pixel from TAPS-1 lines ago while storing the new one.
- Tap k (k<TAPS-1) = output of bank (wr_bank_d+k) mod (TAPS-1), where wr_bank_d is wr_bank registered on accept. Tap TAPS-1 = i_data registered on accept (pix_d).
- col increments on accept and wraps DEPTH-1→0. On wrap: wr_bank advances mod TAPS-1, and lines increments, saturating at TAPS-1.
- FSM: FILL while lines<TAPS-1; FILL→RUN when a wrap brings lines to TAPS-1; RUN persists until i_sof or reset.
- i_sof on accept: treat the pixel as col 0 of a fresh frame. lines←0, FSM←FILL, wr_bank←0. The pixel is written and col←1. i_sof overrides any pending wrap in the same cycle.
- o_valid update, on accept: o_valid←(FSM==RUN & !i_sof). Else if i_ready: o_valid←0.
- o_last registered on accept as (col==DEPTH-1).
- Frame height is not tracked. Downstream uses o_last and counts lines.

## Timing
- Reset (i_rst_n=0 at posedge): o_valid=0, o_last=0, col=0, wr_bank=0, lines=0, FSM=FILL, pix_d=0. o_ready=1 in the first cycle after reset. o_column is don't-care while o_valid=0. Bank contents are not cleared.
- Latency: a pixel accepted at edge N appears on o_column with o_valid=1 after edge N (1 cycle).
- Stall: while o_valid=1 & i_ready=0, o_ready=0 and o_column/o_last hold bit-stable (banks not read).
- Back-to-back: with i_valid=i_ready=1 continuously, one column per cycle with no bubbles, including across line wraps.
- Reset mid-line discards the partial line. The first TAPS-1 lines after reset or i_sof produce no o_valid.

## Test plan
- DEPTH=4, TAPS=3, WIDTH=8; stream rows 0..3 with pixel=row*16+col, i_sof on first, i_ready=1 -> no o_valid for rows 0–1. Row 2 col 1 gives o_column=0x211101. Row 3 col 3 gives 0x332313 with o_last=1. Exactly 8 valid outputs.
- Same stream, i_ready toggled 1-0-0-1 pseudo-randomly -> o_column stable during stalls, o_ready=!o_valid|i_ready, output sequence identical to the no-stall run.
- i_valid gaps of 1–3 cycles mid-line and at the line wrap -> identical column sequence, no duplicated or dropped columns.
- i_sof asserted at row 3 col 0 after rows 0..2 -> no o_valid for that pixel or the next 2 lines. Windows from the new frame contain only new-frame data (bank rotation restarts at wr_bank=0).
- i_rst_n=0 for 1 cycle at row 2 col 2 -> next cycle o_valid=0 and o_ready=1. Restarted stream behaves exactly like the first scenario.
- TAPS=5, DEPTH=8, 6 lines -> first o_valid at row 4 col 0. o_column taps are rows 0..4 at col 0 (0x4030201000 pattern).

Source files
------------

// File: rtl/line_window_if.sv
// Pixel-stream handshake bundle for line_window: raster pixels in, TAPS-tall
// window columns out.
interface line_window_if #(
  parameter int WIDTH = 8,
  parameter int TAPS  = 3
);
  logic                    i_valid;
  logic                    i_sof;
  logic [WIDTH-1:0]        i_data;
  logic                    o_ready;
  logic                    o_valid;
  logic [TAPS*WIDTH-1:0]   o_column;
  logic                    o_last;
  logic                    i_ready;

  modport master (
    output i_valid, i_sof, i_data, i_ready,
    input  o_ready, o_valid, o_column, o_last
  );

  modport slave (
    input  i_valid, i_sof, i_data, i_ready,
    output o_ready, o_valid, o_column, o_last
  );
endinterface

// File: rtl/line_window.sv
// Vertical window generator: buffers the previous TAPS-1 lines in rotating
// row banks and emits, per accepted pixel, the column of pixels above it.
module row_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic             i_clk,
  input  logic             i_re,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);
  logic [WIDTH-1:0] mem_r [DEPTH];

  // Read-before-write line store; o_data holds while i_re is low.
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      o_data <= mem_r[i_addr];
    end
    if (i_we) begin
      mem_r[i_addr] <= i_data;
    end
  end
endmodule

module line_window #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 640,
  parameter int TAPS  = 3
) (
  input logic         i_clk,
  input logic         i_rst_n,
  line_window_if.slave bus
);
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = (TAPS > 2) ? $clog2(TAPS - 1) : 1;
  localparam int LW = $clog2(TAPS);
  localparam int SW = BW + 1;
  localparam int NB = TAPS - 1;

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t                  state_r;
  logic [CW-1:0]           col_r;
  logic [BW-1:0]           wr_bank_r;
  logic [BW-1:0]           wr_bank_d_r;
  logic [LW-1:0]           lines_r;
  logic [WIDTH-1:0]        pix_d_r;
  logic                    o_valid_r;
  logic                    o_last_r;

  logic                    ready_s;
  logic                    accept_s;
  logic [CW-1:0]           eff_col_s;
  logic [BW-1:0]           eff_bank_s;
  logic [NB-1:0]           we_s;
  logic [WIDTH-1:0]        bank_q_s [NB];
  logic [TAPS*WIDTH-1:0]   column_s;
  logic [SW-1:0]           sel_v;

  assign ready_s  = !o_valid_r || bus.i_ready;
  assign accept_s = bus.i_valid && ready_s;
  // A start-of-frame pixel is always line position 0 written into bank 0.
  assign eff_col_s  = bus.i_sof ? {CW{1'b0}} : col_r;
  assign eff_bank_s = bus.i_sof ? {BW{1'b0}} : wr_bank_r;

  // Write enable goes only to the bank currently holding the oldest line.
  always_comb begin
    we_s = '0;
    for (int b = 0; b < NB; b++) begin
      we_s[b] = accept_s && (eff_bank_s == BW'(b));
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_bank
    row_bank #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (CW)
    ) u_bank (
      .i_clk  (i_clk),
      .i_re   (accept_s),
      .i_we   (we_s[g]),
      .i_addr (eff_col_s),
      .i_data (bus.i_data),
      .o_data (bank_q_s[g])
    );
  end

  // Rotate bank outputs so tap 0 is always the oldest buffered line.
  always_comb begin
    column_s = '0;
    sel_v    = '0;
    for (int k = 0; k < NB; k++) begin
      sel_v = {1'b0, wr_bank_d_r} + SW'(k);
      sel_v = (sel_v >= SW'(NB)) ? (sel_v - SW'(NB)) : sel_v;
      column_s[k*WIDTH +: WIDTH] = bank_q_s[sel_v[BW-1:0]];
    end
    column_s[(TAPS-1)*WIDTH +: WIDTH] = pix_d_r;
  end

  // Position tracking, fill/run FSM and output stage.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r     <= FILL;
      col_r       <= '0;
      wr_bank_r   <= '0;
      wr_bank_d_r <= '0;
      lines_r     <= '0;
      pix_d_r     <= '0;
      o_valid_r   <= 1'b0;
      o_last_r    <= 1'b0;
    end else if (accept_s) begin
      pix_d_r     <= bus.i_data;
      wr_bank_d_r <= eff_bank_s;
      o_valid_r   <= (state_r == RUN) && !bus.i_sof;
      o_last_r    <= (eff_col_s == CW'(DEPTH - 1));
      col_r       <= (eff_col_s == CW'(DEPTH - 1)) ? '0 : (eff_col_s + CW'(1));
      if (bus.i_sof) begin
        lines_r   <= '0;
        wr_bank_r <= '0;
        state_r   <= FILL;
      end else if (col_r == CW'(DEPTH - 1)) begin
        wr_bank_r <= (wr_bank_r == BW'(TAPS - 2)) ? '0 : (wr_bank_r + BW'(1));
        lines_r   <= (lines_r == LW'(TAPS - 1)) ? lines_r : (lines_r + LW'(1));
        case (state_r)
          FILL:    state_r <= (lines_r == LW'(TAPS - 2)) ? RUN : FILL;
          RUN:     state_r <= RUN;
          default: state_r <= FILL;
        endcase
      end
    end else if (bus.i_ready) begin
      o_valid_r <= 1'b0;
    end
  end

  assign bus.o_ready  = ready_s;
  assign bus.o_valid  = o_valid_r;
  assign bus.o_last   = o_last_r;
  assign bus.o_column = column_s;
endmodule

// File: tb/tb_line_window.sv
// Directed bench for line_window: a DEPTH=4/TAPS=3 instance exercised through
// fill, stalls, gaps, restart and reset, plus a DEPTH=8/TAPS=5 instance.
module tb_line_window;
  logic clk;
  logic rst_a;
  logic rst_b;
  int   tests;
  int   failed;
  logic mon_en;
  logic use_pat;
  int   pi;
  logic [15:0] pat;
  logic        stall_prev;
  logic [24:0] held;
  logic [24:0] q_a [$];
  logic [24:0] exp_ref [$];
  logic [40:0] q_b [$];

  line_window_if #(.WIDTH(8), .TAPS(3)) a_if ();
  line_window_if #(.WIDTH(8), .TAPS(5)) b_if ();

  line_window #(.WIDTH(8), .DEPTH(4), .TAPS(3)) dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_a),
    .bus     (a_if)
  );

  line_window #(.WIDTH(8), .DEPTH(8), .TAPS(5)) dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_b),
    .bus     (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int idx, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  // Handshake rule, stall stability and output capture for the TAPS=3 instance.
  always @(negedge clk) begin
    if (mon_en) begin
      check("ready_rule", 0, a_if.o_ready, (!a_if.o_valid) | a_if.i_ready);
      if (stall_prev) begin
        check("stall_hold", 0, {a_if.o_last, a_if.o_column}, held);
      end
      stall_prev <= a_if.o_valid & !a_if.i_ready;
      held       <= {a_if.o_last, a_if.o_column};
      if (a_if.o_valid && a_if.i_ready) begin
        q_a.push_back({a_if.o_last, a_if.o_column});
      end
    end
  end

  always @(negedge clk) begin
    if (b_if.o_valid && b_if.i_ready) begin
      q_b.push_back({b_if.o_last, b_if.o_column});
    end
  end

  task automatic step_ready();
    a_if.i_ready = use_pat ? pat[pi % 16] : 1'b1;
    pi = pi + 1;
  endtask

  task automatic send_a(input logic [7:0] d, input logic sof);
    int n;
    @(posedge clk); #1;
    a_if.i_valid = 1'b1;
    a_if.i_data  = d;
    a_if.i_sof   = sof;
    step_ready();
    n = 0;
    @(negedge clk);
    while (!a_if.o_ready && n < 50) begin
      @(posedge clk); #1;
      step_ready();
      @(negedge clk);
      n++;
    end
    if (!a_if.o_ready) begin
      tests++;
      failed++;
      $error("FAIL accept_timeout[%0d]: observed no o_ready expected o_ready within 50 cycles", d);
    end
  endtask

  task automatic idle_a(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      a_if.i_valid = 1'b0;
      a_if.i_sof   = 1'b0;
      step_ready();
    end
  endtask

  task automatic drain_a();
    use_pat = 1'b0;
    idle_a(4);
  endtask

  function automatic int gap_of(input int i);
    case (i)
      1:       return 1;
      3:       return 2;
      6:       return 3;
      7:       return 1;
      11:      return 3;
      default: return 0;
    endcase
  endfunction

  // Raster stream pixel = base + row*16 + col, i_sof on the first pixel.
  task automatic stream_a(input int npix, input logic [7:0] base, input logic gaps);
    for (int i = 0; i < npix; i++) begin
      send_a(base + 8'((i / 4) * 16 + (i % 4)), (i == 0));
      if (gaps && gap_of(i) > 0) idle_a(gap_of(i));
    end
  endtask

  task automatic cmp_ref(input string tag);
    check({tag, "_count"}, 0, q_a.size(), exp_ref.size());
    for (int i = 0; i < exp_ref.size(); i++) begin
      if (i < q_a.size()) check(tag, i, q_a[i], exp_ref[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [24:0] e;
    tests = 0; failed = 0; mon_en = 1'b0; use_pat = 1'b0; pi = 0;
    pat = 16'b1001_1001_0110_1001;
    stall_prev = 1'b0; held = '0;
    rst_a = 1'b0; rst_b = 1'b0;
    a_if.i_valid = 1'b0; a_if.i_sof = 1'b0; a_if.i_data = 8'h00; a_if.i_ready = 1'b1;
    b_if.i_valid = 1'b0; b_if.i_sof = 1'b0; b_if.i_data = 8'h00; b_if.i_ready = 1'b1;

    for (int r = 2; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        e = {(c == 3) ? 1'b1 : 1'b0, 8'(r * 16 + c), 8'((r - 1) * 16 + c), 8'((r - 2) * 16 + c)};
        exp_ref.push_back(e);
      end
    end

    repeat (2) @(posedge clk);
    #1; rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);
    check("rst_valid_a", 0, a_if.o_valid, 1'b0);
    check("rst_last_a", 0, a_if.o_last, 1'b0);
    check("rst_ready_a", 0, a_if.o_ready, 1'b1);
    check("rst_valid_b", 0, b_if.o_valid, 1'b0);
    check("rst_ready_b", 0, b_if.o_ready, 1'b1);
    mon_en = 1'b1;

    // Straight stream, no stalls: rows 0..1 fill, rows 2..3 produce windows.
    q_a.delete();
    stream_a(16, 8'h00, 1'b0);
    @(posedge clk); #1;
    a_if.i_valid = 1'b0; a_if.i_sof = 1'b0;
    @(negedge clk);
    check("lat_valid", 0, a_if.o_valid, 1'b1);
    check("lat_column", 0, a_if.o_column, 24'h332313);
    check("lat_last", 0, a_if.o_last, 1'b1);
    idle_a(3);
    cmp_ref("s1");
    if (q_a.size() >= 8) begin
      check("s1_r2c1", 0, q_a[1], {1'b0, 24'h211101});
      check("s1_r3c3", 0, q_a[7], {1'b1, 24'h332313});
    end

    // Downstream back-pressure.
    q_a.delete();
    use_pat = 1'b1; pi = 0;
    stream_a(16, 8'h00, 1'b0);
    drain_a();
    cmp_ref("s2");

    // Input bubbles mid-line and at line wraps.
    q_a.delete();
    stream_a(16, 8'h00, 1'b1);
    drain_a();
    cmp_ref("s3");

    // New frame after three lines: only old row 2 and new row 2 emit.
    q_a.delete();
    stream_a(12, 8'h00, 1'b0);
    stream_a(12, 8'h80, 1'b0);
    drain_a();
    check("s4_count", 0, q_a.size(), 8);
    for (int i = 0; i < 8; i++) begin
      e = (i < 4) ? exp_ref[i]
                  : {(i == 7) ? 1'b1 : 1'b0, 8'(8'hA0 + i - 4), 8'(8'h90 + i - 4), 8'(8'h80 + i - 4)};
      if (i < q_a.size()) check("s4", i, q_a[i], e);
    end

    // Reset in the middle of row 2, then a clean restart.
    q_a.delete();
    stream_a(10, 8'h00, 1'b0);
    @(posedge clk); #1;
    rst_a = 1'b0; a_if.i_valid = 1'b0; a_if.i_sof = 1'b0;
    @(posedge clk); #1;
    rst_a = 1'b1;
    @(negedge clk);
    check("s5_rst_valid", 0, a_if.o_valid, 1'b0);
    check("s5_rst_ready", 0, a_if.o_ready, 1'b1);
    q_a.delete();
    stream_a(16, 8'h00, 1'b0);
    drain_a();
    cmp_ref("s5");

    // TAPS=5, DEPTH=8, six lines.
    for (int i = 0; i < 48; i++) begin
      @(posedge clk); #1;
      b_if.i_valid = 1'b1;
      b_if.i_data  = 8'((i / 8) * 16 + (i % 8));
      b_if.i_sof   = (i == 0);
    end
    @(posedge clk); #1;
    b_if.i_valid = 1'b0; b_if.i_sof = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("s6_count", 0, q_b.size(), 16);
    if (q_b.size() >= 16) begin
      check("s6_r4c0", 0, q_b[0], {1'b0, 40'h4030201000});
      check("s6_r4c7", 0, q_b[7], {1'b1, 40'h4737271707});
      check("s6_r5c7", 0, q_b[15], {1'b1, 40'h5747372717});
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
